core_trap_csr: RTL and testbench

- Downstream consumer of the trap handler's exception_valid/exception_cause/exception_value. Owns the trap-related machine and supervisor CSRs and the current privilege level.
- Performs trap entry with medeleg-based delegation to S-mode, plus MRET/SRET return.
- Emits a registered one-cycle redirect (target PC plus flush) to fetch.
- Serves combinational CSR reads and commits CSR writes for its address range.

---
 rtl/core_trap_csr.sv | 257 +++++++++++++++++++++++++
 tb/tb_core_trap_csr.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_trap_csr.sv
// Trap CSR block: owns M/S trap CSRs and the current privilege level, performs
// trap entry with medeleg delegation, MRET/SRET, and emits a one-cycle redirect.

package core_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [4:0] {
        EXC_INSTR_MISALIGNED = 5'd0,
        EXC_INSTR_FAULT      = 5'd1,
        EXC_ILLEGAL_INSTR    = 5'd2,
        EXC_BREAKPOINT       = 5'd3,
        EXC_LOAD_MISALIGNED  = 5'd4,
        EXC_LOAD_FAULT       = 5'd5,
        EXC_STORE_MISALIGNED = 5'd6,
        EXC_STORE_FAULT      = 5'd7,
        EXC_ECALL_U          = 5'd8,
        EXC_ECALL_S          = 5'd9,
        EXC_ECALL_M          = 5'd11,
        EXC_INSTR_PAGE_FAULT = 5'd12,
        EXC_LOAD_PAGE_FAULT  = 5'd13,
        EXC_STORE_PAGE_FAULT = 5'd15
    } exception_e;

endpackage

module core_trap_csr
    import core_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire,
    input  logic [31:0] pc,
    input  logic        exception_valid,
    input  exception_e  exception_cause,
    input  logic [31:0] exception_value,
    input  logic        mret,
    input  logic        sret,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output priv_e       priv,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int unsigned XLEN = 32;

    localparam logic [11:0] ADDR_SSTATUS = 12'h100;
    localparam logic [11:0] ADDR_STVEC   = 12'h105;
    localparam logic [11:0] ADDR_SEPC    = 12'h141;
    localparam logic [11:0] ADDR_SCAUSE  = 12'h142;
    localparam logic [11:0] ADDR_STVAL   = 12'h143;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEDELEG = 12'h302;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [XLEN-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] MEDELEG_MASK = 32'hFFFF_F7FF;

    // Architectural state
    priv_e            priv_q, priv_d;
    logic             sie_q, sie_d;
    logic             mie_q, mie_d;
    logic             spie_q, spie_d;
    logic             mpie_q, mpie_d;
    logic             spp_q, spp_d;
    logic [1:0]       mpp_q, mpp_d;
    logic [XLEN-1:0]  medeleg_q, medeleg_d;
    logic [XLEN-1:0]  mtvec_q, mtvec_d;
    logic [XLEN-1:0]  stvec_q, stvec_d;
    logic [XLEN-1:0]  mepc_q, mepc_d;
    logic [XLEN-1:0]  sepc_q, sepc_d;
    logic [XLEN-1:0]  mcause_q, mcause_d;
    logic [XLEN-1:0]  scause_q, scause_d;
    logic [XLEN-1:0]  mtval_q, mtval_d;
    logic [XLEN-1:0]  stval_q, stval_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

    logic             deleg;
    logic [XLEN-1:0]  mstatus_view;
    logic [XLEN-1:0]  sstatus_view;

    assign deleg = (priv_q != PRIV_M) && medeleg_q[exception_cause];

    assign mstatus_view = {19'b0, mpp_q, 2'b00, spp_q, mpie_q, 1'b0, spie_q,
                           1'b0, mie_q, 1'b0, sie_q, 1'b0};
    assign sstatus_view = {23'b0, spp_q, 2'b00, spie_q, 3'b000, sie_q, 1'b0};

    // Combinational CSR read port
    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = mstatus_view;
            ADDR_SSTATUS: csr_rdata = sstatus_view;
            ADDR_MEDELEG: csr_rdata = medeleg_q;
            ADDR_MTVEC:   csr_rdata = mtvec_q;
            ADDR_STVEC:   csr_rdata = stvec_q;
            ADDR_MEPC:    csr_rdata = mepc_q;
            ADDR_SEPC:    csr_rdata = sepc_q;
            ADDR_MCAUSE:  csr_rdata = mcause_q;
            ADDR_SCAUSE:  csr_rdata = scause_q;
            ADDR_MTVAL:   csr_rdata = mtval_q;
            ADDR_STVAL:   csr_rdata = stval_q;
            default:      csr_hit   = 1'b0;
        endcase
    end

    // Next-state: one prioritised event per retiring instruction
    always_comb begin
        priv_d           = priv_q;
        sie_d            = sie_q;
        mie_d            = mie_q;
        spie_d           = spie_q;
        mpie_d           = mpie_q;
        spp_d            = spp_q;
        mpp_d            = mpp_q;
        medeleg_d        = medeleg_q;
        mtvec_d          = mtvec_q;
        stvec_d          = stvec_q;
        mepc_d           = mepc_q;
        sepc_d           = sepc_q;
        mcause_d         = mcause_q;
        scause_d         = scause_q;
        mtval_d          = mtval_q;
        stval_d          = stval_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (retire) begin
            if (exception_valid) begin
                redirect_valid_d = 1'b1;
                if (deleg) begin
                    sepc_d        = pc & ALIGN_MASK;
                    scause_d      = {27'b0, exception_cause};
                    stval_d       = exception_value;
                    spp_d         = (priv_q == PRIV_S);
                    spie_d        = sie_q;
                    sie_d         = 1'b0;
                    priv_d        = PRIV_S;
                    redirect_pc_d = stvec_q;
                end else begin
                    mepc_d        = pc & ALIGN_MASK;
                    mcause_d      = {27'b0, exception_cause};
                    mtval_d       = exception_value;
                    mpp_d         = priv_q;
                    mpie_d        = mie_q;
                    mie_d         = 1'b0;
                    priv_d        = PRIV_M;
                    redirect_pc_d = mtvec_q;
                end
            end else if (mret) begin
                redirect_valid_d = 1'b1;
                priv_d           = priv_e'(mpp_q);
                mie_d            = mpie_q;
                mpie_d           = 1'b1;
                mpp_d            = PRIV_U;
                redirect_pc_d    = mepc_q;
            end else if (sret) begin
                redirect_valid_d = 1'b1;
                priv_d           = spp_q ? PRIV_S : PRIV_U;
                sie_d            = spie_q;
                spie_d           = 1'b1;
                spp_d            = 1'b0;
                redirect_pc_d    = sepc_q;
            end else if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        sie_d  = csr_wdata[1];
                        mie_d  = csr_wdata[3];
                        spie_d = csr_wdata[5];
                        mpie_d = csr_wdata[7];
                        spp_d  = csr_wdata[8];
                        // Reserved MPP encoding falls back to U
                        mpp_d  = (csr_wdata[12:11] == 2'b10) ? 2'b00 : csr_wdata[12:11];
                    end
                    ADDR_SSTATUS: begin
                        sie_d  = csr_wdata[1];
                        spie_d = csr_wdata[5];
                        spp_d  = csr_wdata[8];
                    end
                    ADDR_MEDELEG: medeleg_d = csr_wdata & MEDELEG_MASK;
                    ADDR_MTVEC:   mtvec_d   = csr_wdata & ALIGN_MASK;
                    ADDR_STVEC:   stvec_d   = csr_wdata & ALIGN_MASK;
                    ADDR_MEPC:    mepc_d    = csr_wdata & ALIGN_MASK;
                    ADDR_SEPC:    sepc_d    = csr_wdata & ALIGN_MASK;
                    ADDR_MCAUSE:  mcause_d  = csr_wdata;
                    ADDR_SCAUSE:  scause_d  = csr_wdata;
                    ADDR_MTVAL:   mtval_d   = csr_wdata;
                    ADDR_STVAL:   stval_d   = csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            priv_q           <= PRIV_M;
            sie_q            <= 1'b0;
            mie_q            <= 1'b0;
            spie_q           <= 1'b0;
            mpie_q           <= 1'b0;
            spp_q            <= 1'b0;
            mpp_q            <= 2'b00;
            medeleg_q        <= '0;
            mtvec_q          <= MTVEC_RESET & ALIGN_MASK;
            stvec_q          <= '0;
            mepc_q           <= '0;
            sepc_q           <= '0;
            mcause_q         <= '0;
            scause_q         <= '0;
            mtval_q          <= '0;
            stval_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            priv_q           <= priv_d;
            sie_q            <= sie_d;
            mie_q            <= mie_d;
            spie_q           <= spie_d;
            mpie_q           <= mpie_d;
            spp_q            <= spp_d;
            mpp_q            <= mpp_d;
            medeleg_q        <= medeleg_d;
            mtvec_q          <= mtvec_d;
            stvec_q          <= stvec_d;
            mepc_q           <= mepc_d;
            sepc_q           <= sepc_d;
            mcause_q         <= mcause_d;
            scause_q         <= scause_d;
            mtval_q          <= mtval_d;
            stval_q          <= stval_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign priv           = priv_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_core_trap_csr.sv
// Directed bench for core_trap_csr: trap entry, delegation, MRET/SRET,
// event priority, write legalisation and reset behaviour.

module tb_core_trap_csr;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire;
    logic [31:0] pc;
    logic        exception_valid;
    exception_e  exception_cause;
    logic [31:0] exception_value;
    logic        mret;
    logic        sret;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    priv_e       priv;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    core_trap_csr #(.MTVEC_RESET(32'h8000_0003)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .retire          (retire),
        .pc              (pc),
        .exception_valid (exception_valid),
        .exception_cause (exception_cause),
        .exception_value (exception_value),
        .mret            (mret),
        .sret            (sret),
        .csr_addr        (csr_addr),
        .csr_we          (csr_we),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .csr_hit         (csr_hit),
        .priv            (priv),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        retire          = 1'b0;
        exception_valid = 1'b0;
        mret            = 1'b0;
        sret            = 1'b0;
        csr_we          = 1'b0;
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        retire    = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
    endtask

    task automatic exc(input exception_e c, input logic [31:0] v, input logic [31:0] p);
        retire          = 1'b1;
        exception_valid = 1'b1;
        exception_cause = c;
        exception_value = v;
        pc              = p;
        tick();
    endtask

    task automatic chk_redirect(input string tag, input logic v, input logic [31:0] tgt);
        check({tag, "_valid"}, 32'(redirect_valid), 32'(v));
        check({tag, "_pc"}, redirect_pc, tgt);
    endtask

    initial begin
        idle_inputs();
        rst_n           = 1'b0;
        pc              = '0;
        exception_cause = EXC_INSTR_MISALIGNED;
        exception_value = '0;
        csr_addr        = '0;
        csr_wdata       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. Reset state
        check("rst_priv", 32'(priv), 32'(PRIV_M));
        chk_redirect("rst_redir", 1'b0, 32'h0);
        chk_csr("rst_mtvec", 12'h305, 32'h8000_0000);
        check("rst_mtvec_hit", 32'(csr_hit), 32'd1);
        chk_csr("rst_mstatus", 12'h300, 32'h0);
        chk_csr("miss_rdata", 12'h304, 32'h0);
        check("miss_hit", 32'(csr_hit), 32'd0);

        // 2. Non-delegated trap from M
        wr(12'h300, 32'h0000_0008);
        exc(EXC_ILLEGAL_INSTR, 32'hDEAD_BEEF, 32'h100);
        chk_redirect("t2_redir", 1'b1, 32'h8000_0000);
        check("t2_priv", 32'(priv), 32'(PRIV_M));
        chk_csr("t2_mepc", 12'h341, 32'h100);
        chk_csr("t2_mcause", 12'h342, 32'd2);
        chk_csr("t2_mtval", 12'h343, 32'hDEAD_BEEF);
        chk_csr("t2_mstatus", 12'h300, 32'h1880);
        tick();
        chk_redirect("t2_after", 1'b0, 32'h8000_0000);

        // 3. Drop to U via MRET, then delegated ecall-U
        wr(12'h300, 32'h0000_0080);
        wr(12'h341, 32'h200);
        mret = 1'b1; retire = 1'b1;
        tick();
        chk_redirect("t3_mret", 1'b1, 32'h200);
        check("t3_priv_u", 32'(priv), 32'(PRIV_U));
        chk_csr("t3_mstatus_u", 12'h300, 32'h88);
        wr(12'h105, 32'h0000_3001);
        chk_csr("t3_stvec", 12'h105, 32'h3000);
        wr(12'h302, 32'h0000_0100);
        wr(12'h100, 32'h0000_0002);
        exc(EXC_ECALL_U, 32'h55, 32'h207);
        chk_redirect("t3_deleg", 1'b1, 32'h3000);
        check("t3_priv_s", 32'(priv), 32'(PRIV_S));
        chk_csr("t3_sepc", 12'h141, 32'h204);
        chk_csr("t3_scause", 12'h142, 32'd8);
        chk_csr("t3_stval", 12'h143, 32'h55);
        chk_csr("t3_sstatus", 12'h100, 32'h20);
        chk_csr("t3_mepc_keep", 12'h341, 32'h200);

        // Back-to-back traps: delegated from S, then non-delegated from S
        exc(EXC_ECALL_U, 32'h0, 32'h300);
        chk_redirect("t3_b2b1", 1'b1, 32'h3000);
        exc(EXC_ILLEGAL_INSTR, 32'h0, 32'h304);
        chk_redirect("t3_b2b2", 1'b1, 32'h8000_0000);
        check("t3_b2b_priv", 32'(priv), 32'(PRIV_M));
        chk_csr("t3_b2b_mstatus", 12'h300, 32'h980);
        chk_csr("t3_b2b_sepc", 12'h141, 32'h300);
        chk_csr("t3_b2b_mepc", 12'h341, 32'h304);

        // From M with medeleg[8] set: not delegated
        exc(EXC_ECALL_U, 32'h0, 32'h500);
        chk_redirect("t3_m_nodeleg", 1'b1, 32'h8000_0000);
        check("t3_m_priv", 32'(priv), 32'(PRIV_M));
        chk_csr("t3_m_mepc", 12'h341, 32'h500);
        chk_csr("t3_m_mcause", 12'h342, 32'd8);
        chk_csr("t3_m_sepc", 12'h141, 32'h300);
        chk_csr("t3_m_mstatus", 12'h300, 32'h1900);

        // 4. MRET to S, then SRET to U
        wr(12'h300, 32'h0000_0880);
        wr(12'h341, 32'h400);
        mret = 1'b1; retire = 1'b1;
        tick();
        chk_redirect("t4_mret", 1'b1, 32'h400);
        check("t4_priv_s", 32'(priv), 32'(PRIV_S));
        chk_csr("t4_mstatus", 12'h300, 32'h88);
        tick();
        check("t4_pulse_end", 32'(redirect_valid), 32'd0);
        sret = 1'b1; retire = 1'b1;
        tick();
        chk_redirect("t4_sret", 1'b1, 32'h300);
        check("t4_priv_u", 32'(priv), 32'(PRIV_U));
        chk_csr("t4_mstatus_sret", 12'h300, 32'hA8);

        // 5. Priority: exception beats mret and csr write
        retire = 1'b1; mret = 1'b1; csr_we = 1'b1;
        csr_addr = 12'h305; csr_wdata = 32'h0000_4444;
        exception_valid = 1'b1; exception_cause = EXC_ILLEGAL_INSTR;
        exception_value = 32'h0; pc = 32'h600;
        tick();
        chk_redirect("t5_prio", 1'b1, 32'h8000_0000);
        check("t5_priv", 32'(priv), 32'(PRIV_M));
        chk_csr("t5_mtvec", 12'h305, 32'h8000_0000);
        chk_csr("t5_mepc", 12'h341, 32'h600);
        exception_valid = 1'b1; exception_cause = EXC_BREAKPOINT; pc = 32'h700;
        tick();
        check("t5_noretire_pulse", 32'(redirect_valid), 32'd0);
        chk_csr("t5_noretire_mepc", 12'h341, 32'h600);
        chk_csr("t5_noretire_mcause", 12'h342, 32'd2);

        // 6. Write legalisation
        wr(12'h300, 32'h0000_1000);
        chk_csr("t6_mpp10", 12'h300, 32'h0);
        wr(12'h302, 32'hFFFF_FFFF);
        chk_csr("t6_medeleg", 12'h302, 32'hFFFF_F7FF);
        wr(12'h341, 32'h123);
        chk_csr("t6_mepc", 12'h341, 32'h120);
        wr(12'h100, 32'hFFFF_FFFF);
        chk_csr("t6_sstatus", 12'h100, 32'h122);
        chk_csr("t6_mstatus", 12'h300, 32'h122);
        wr(12'h142, 32'hFFFF_FFFF);
        chk_csr("t6_scause", 12'h142, 32'hFFFF_FFFF);

        // Same-cycle write and read returns old value
        retire = 1'b1; csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h999;
        #1;
        check("t6_rw_old", csr_rdata, 32'h120);
        tick();
        chk_csr("t6_rw_new", 12'h341, 32'h998);

        // Reset while a redirect pulse is high
        exc(EXC_ILLEGAL_INSTR, 32'h0, 32'h800);
        check("t7_pre_pulse", 32'(redirect_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_redirect("t7_rst", 1'b0, 32'h0);
        check("t7_priv", 32'(priv), 32'(PRIV_M));
        chk_csr("t7_medeleg", 12'h302, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
